// File: rtl/uart_pkg.sv
// uart_pkg: shared state, parity and frame-format definitions for the uart_fc core.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    localparam int MIN_DIV = 4;

    function automatic logic [3:0] dbits_decode(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter flagging mid-bit and last cycle of each period.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             mid,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt;

    assign mid     = cnt == (div >> 1);
    assign bit_end = cnt == div - 1'b1;

    always_ff @(posedge clk) begin
        if (!nrst || clear)
            cnt <= '0;
        else
            cnt <= bit_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_fc.sv
// uart_fc: runtime-configurable full-duplex UART (5-8 data bits, parity, 1/2 stop bits).
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_fc
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             rx,
    output logic             tx,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_dbits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_done,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_break
);

    localparam int DEF_DIV = CLK_FREQ / BAUD_RATE;

    if (DEF_DIV < MIN_DIV) begin : g_div_chk
        $error("uart_fc: CLK_FREQ/BAUD_RATE below minimum divider");
    end

    logic [DIV_W-1:0] div_c;
    logic [3:0]       n_c;
    logic [7:0]       mask_c;
    logic             pen_c, odd_c;

    assign div_c  = cfg_div < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : cfg_div;
    assign n_c    = dbits_decode(cfg_dbits);
    assign mask_c = 8'hFF >> (4'd8 - n_c);

`ifdef UART_PARITY_EN
    assign pen_c = cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD;
    assign odd_c = cfg_parity == PAR_ODD;
`else
    logic unused_par;
    assign unused_par = ^cfg_parity;
    assign pen_c = 1'b0;
    assign odd_c = 1'b0;
`endif

    uart_state_t      t_state;
    logic [DIV_W-1:0] t_div;
    logic [3:0]       t_n;
    logic [7:0]       t_sh;
    logic [2:0]       t_bidx;
    logic             t_pen, t_pbit, t_stop2, t_sidx;
    logic             t_mid_unused, t_end;

    uart_bit_timer #(.DIV_W(DIV_W)) u_tx_tmr (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (t_state == IDLE),
        .div     (t_div),
        .mid     (t_mid_unused),
        .bit_end (t_end)
    );

    assign tx_done = t_state == STOP && t_end && t_sidx == t_stop2;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            t_state  <= IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            t_div    <= '0;
            t_n      <= '0;
            t_sh     <= '0;
            t_bidx   <= '0;
            t_pen    <= 1'b0;
            t_pbit   <= 1'b0;
            t_stop2  <= 1'b0;
            t_sidx   <= 1'b0;
        end else begin
            case (t_state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        t_state  <= START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        t_div    <= div_c;
                        t_n      <= n_c;
                        t_pen    <= pen_c;
                        t_stop2  <= cfg_stop2;
                        t_sh     <= tx_data & mask_c;
                        t_pbit   <= ^(tx_data & mask_c) ^ odd_c;
                    end
                end
                START: if (t_end) begin
                    t_state <= DATA;
                    tx      <= t_sh[0];
                    t_sh    <= t_sh >> 1;
                    t_bidx  <= '0;
                end
                DATA: if (t_end) begin
                    if ({1'b0, t_bidx} == t_n - 4'd1) begin
                        t_state <= t_pen ? PARITY : STOP;
                        tx      <= t_pen ? t_pbit : 1'b1;
                        t_sidx  <= 1'b0;
                    end else begin
                        t_bidx <= t_bidx + 1'b1;
                        tx     <= t_sh[0];
                        t_sh   <= t_sh >> 1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: if (t_end) begin
                    t_state <= STOP;
                    tx      <= 1'b1;
                end
`endif
                STOP: if (t_end) begin
                    if (t_sidx == t_stop2) begin
                        t_state  <= IDLE;
                        tx_ready <= 1'b1;
                    end else
                        t_sidx <= 1'b1;
                end
                default: begin
                    t_state <= IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

    uart_state_t      r_state;
    logic [1:0]       rx_sync;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_n;
    logic [7:0]       r_sh;
    logic [2:0]       r_bidx;
    logic             r_pen, r_odd, r_pbit;
    logic             r_mid, r_end, rs;

    assign rs = rx_sync[1];

    uart_bit_timer #(.DIV_W(DIV_W)) u_rx_tmr (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (r_state == IDLE || r_state == WAIT_HIGH),
        .div     (r_div),
        .mid     (r_mid),
        .bit_end (r_end)
    );

    // The timer runs from the start edge, so every mid count lands mid-bit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rx_sync       <= 2'b11;
            r_state       <= IDLE;
            r_div         <= '0;
            r_n           <= '0;
            r_sh          <= '0;
            r_bidx        <= '0;
            r_pen         <= 1'b0;
            r_odd         <= 1'b0;
            r_pbit        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_valid <= 1'b0;
            case (r_state)
                IDLE: if (!rs) begin
                    r_state <= START;
                    r_div   <= div_c;
                    r_n     <= n_c;
                    r_pen   <= pen_c;
                    r_odd   <= odd_c;
                    r_sh    <= '0;
                    r_pbit  <= 1'b0;
                    r_bidx  <= '0;
                end
                START: begin
                    if (r_mid && rs)
                        r_state <= IDLE;
                    else if (r_end)
                        r_state <= DATA;
                end
                DATA: begin
                    if (r_mid)
                        r_sh[r_bidx] <= rs;
                    if (r_end) begin
                        if ({1'b0, r_bidx} == r_n - 4'd1)
                            r_state <= r_pen ? PARITY : STOP;
                        else
                            r_bidx <= r_bidx + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (r_mid)
                        r_pbit <= rs;
                    if (r_end)
                        r_state <= STOP;
                end
`endif
                STOP: if (r_mid) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= r_sh;
                    rx_frame_err  <= !rs;
                    rx_parity_err <= r_pen && (r_pbit != (^r_sh ^ r_odd));
                    rx_break      <= !rs && r_sh == 8'd0 && !r_pbit;
                    r_state       <= WAIT_HIGH;
                end
                WAIT_HIGH: if (rs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fc.sv
// tb_uart_fc: directed self-checking bench for uart_fc (cfg_div 16 unless noted).
module tb_uart_fc;

    logic        clk = 1'b0, nrst = 1'b0, loop = 1'b0, rx_drv = 1'b1;
    logic        rx, tx, tx_ready, tx_done, rx_valid;
    logic        rx_parity_err, rx_frame_err, rx_break;
    logic [15:0] cfg_div = 16'd16;
    logic [1:0]  cfg_dbits = 2'd3, cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0, tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00, rx_data;

    int n_chk = 0, n_pass = 0, rx_cnt = 0, c0, done_at;
    logic [9:0] bits;

    always #5 clk = ~clk;

    assign rx = loop ? tx : rx_drv;

    uart_fc dut (
        .clk(clk), .nrst(nrst), .rx(rx), .tx(tx),
        .cfg_div(cfg_div), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_break(rx_break)
    );

    always @(posedge clk) if (rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; samples tx at each mid-bit assuming a 16-cycle bit.
    task automatic send_tx(input logic [7:0] d, input int cycles, output int done, output logic [9:0] b);
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge clk);
        done = -1;
        b = '1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (tx_done && done < 0) done = i;
            if ((i - 1) % 16 == 8 && (i - 1) / 16 < 10) b[(i - 1) / 16] = tx;
        end
    endtask

    task automatic drive_rx(input logic [15:0] v, input int nb);
        for (int b = 0; b < nb; b++) begin
            rx_drv = v[b];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        loop = 1'b1;
        send_tx(8'hA5, 165, done_at, bits);
        check("8n1_bits", bits, {1'b1, 8'hA5, 1'b0});
        check("8n1_done", done_at, 160);
        check("8n1_ready", tx_ready, 1);
        check("8n1_rx_cnt", rx_cnt, 1);
        check("8n1_rx_data", rx_data, 8'hA5);
        check("8n1_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);

        cfg_dbits = 2'd0; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
        c0 = rx_cnt;
        send_tx(8'h1F, 165, done_at, bits);
        check("5e2_bits", bits[8:0], 9'h1FE);
`ifdef UART_PARITY_EN
        check("5e2_done", done_at, 144);
`else
        check("5n2_done", done_at, 128);
`endif
        check("5e2_rx_cnt", rx_cnt, c0 + 1);
        check("5e2_rx_data", rx_data, 8'h1F);
        check("5e2_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);
        loop = 1'b0;
        repeat (20) @(negedge clk);

        cfg_dbits = 2'd3; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
        c0 = rx_cnt;
        drive_rx({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (16) @(negedge clk);
        check("par_rx_cnt", rx_cnt, c0 + 1);
        check("par_rx_data", rx_data, 8'h03);
`ifdef UART_PARITY_EN
        check("par_flags", {rx_parity_err, rx_frame_err, rx_break}, 3'b100);
`else
        check("nopar_flags", {rx_parity_err, rx_frame_err, rx_break}, 3'b010);
`endif

        cfg_parity = 2'd0;
        c0 = rx_cnt;
        rx_drv = 1'b0;
        repeat (320) @(negedge clk);
        check("brk_rx_cnt", rx_cnt, c0 + 1);
        check("brk_flags", {rx_parity_err, rx_frame_err, rx_break}, 3'b011);
        check("brk_rx_data", rx_data, 0);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_no_retrig", rx_cnt, c0 + 1);

        c0 = rx_cnt;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_rx_cnt", rx_cnt, c0);
        drive_rx({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (16) @(negedge clk);
        check("post_glitch_cnt", rx_cnt, c0 + 1);
        check("post_glitch_data", rx_data, 8'h5A);

        tx_data = 8'h3C; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_ready", tx_ready, 0);
        check("midrst_done", tx_done, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", tx_ready, 1);

        tx_data = 8'h00; tx_valid = 1'b1;
        @(posedge clk);
        done_at = -1;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (i == 20) cfg_div = 16'd8;
            if (tx_done && done_at < 0) done_at = i;
        end
        check("cfgchg_done", done_at, 160);

        cfg_div = 16'd2;
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(posedge clk);
        done_at = -1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (tx_done && done_at < 0) done_at = i;
            if (i == 41) begin
                check("b2b_idle_tx", tx, 1);
                check("b2b_idle_ready", tx_ready, 1);
            end
            if (i == 42) begin
                check("b2b_start_tx", tx, 0);
                tx_valid = 1'b0;
            end
        end
        check("clamp_done", done_at, 40);
        repeat (50) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
